hazard_ctrl: RTL and testbench

//  Pipeline control for the 5-stage core. Drives the 2-bit sel_i of every stage register
//  (IF_ID, ID_EX, EX_MEM, MEM_WB) and the PC enable. Resolves load-use stalls, EX-resolved

---
 rtl/hazard_pkg.sv | 39 +++
 rtl/fwd_unit.sv | 25 ++
 rtl/hazard_ctrl.sv | 178 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The wb_sel encodings are shared with the decoder and must stay in step with it.
package hazard_pkg;

  // Stage register control. 2'b10 is never driven.
  typedef enum logic [1:0] {
    SEL_LOAD  = 2'b00,
    SEL_HOLD  = 2'b01,
    SEL_FLUSH = 2'b11
  } sel_e;

  // EX operand source.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_e;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    TIMEOUT  = 2'b10
  } state_e;

  // Writeback source select, as produced by the decoder.
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  localparam int unsigned MEM_TIMEOUT_DEF = 64;
  localparam int unsigned CNT_W_DEF       = 16;

  // True when a writing stage targets the given source register (x0 excluded).
  function automatic logic rd_hit(input logic wren, input logic [4:0] rd, input logic [4:0] rs);
    return wren && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// EX operand forwarding compare for one operand.
// The MEM stage wins over WB; a load in MEM cannot forward yet and falls through to WB.
module fwd_unit
  import hazard_pkg::*;
(
  input  logic [4:0] ex_rs_addr,
  input  logic [4:0] mem_rd_ad,
  input  logic       mem_rd_wren,
  input  logic [1:0] mem_wb_sel,
  input  logic [4:0] wb_rd_ad,
  input  logic       wb_rd_wren,
  output logic [1:0] fwd
);

  // Pick the youngest producer of the operand.
  always_comb begin
    fwd = FWD_RF;
    if (rd_hit(mem_rd_wren, mem_rd_ad, ex_rs_addr) && (mem_wb_sel != WB_MEM)) begin
      fwd = FWD_MEM;
    end else if (rd_hit(wb_rd_wren, wb_rd_ad, ex_rs_addr)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: stage register selects, PC enable,
// memory-wait watchdog and EX forwarding selects. Outputs are Mealy: decoded from the
// registered state and the current inputs, consumed by the stage registers next edge.
// Optional build macro HAZARD_PERF_EN adds saturating stall/flush performance counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow; branch flush and load-use bubble resolved here
// MEM_WAIT | data memory busy; whole pipe held, wait_cnt tracks duration
// TIMEOUT  | memory never returned; pipe flushed until reset
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic [4:0]       ex_rs1_addr_i,
  input  logic [4:0]       ex_rs2_addr_i,
  input  logic [4:0]       ex_rd_ad_i,
  input  logic             ex_rd_wren_i,
  input  logic [1:0]       ex_wb_sel_i,
  input  logic             ex_br_taken_i,
  input  logic [4:0]       mem_rd_ad_i,
  input  logic             mem_rd_wren_i,
  input  logic [1:0]       mem_wb_sel_i,
  input  logic [4:0]       wb_rd_ad_i,
  input  logic             wb_rd_wren_i,
  input  logic             mem_busy_i,
  output logic             pc_en_o,
  output logic [1:0]       if_id_sel_o,
  output logic [1:0]       id_ex_sel_o,
  output logic [1:0]       ex_mem_sel_o,
  output logic [1:0]       mem_wb_sel_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
`endif
  output logic             mem_timeout_o
);

  localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);

  state_e            state_q;
  logic [WCNT_W-1:0] wait_cnt_q;
  logic [WCNT_W-1:0] wait_cnt_inc;
  logic              wait_expired;
  logic              load_use;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  sel_e              if_id_sel;
  sel_e              id_ex_sel;
  sel_e              ex_mem_sel;
  sel_e              mem_wb_sel;

  assign load_use = (ex_wb_sel_i == WB_MEM) &&
                    (rd_hit(ex_rd_wren_i, ex_rd_ad_i, id_rs1_addr_i) ||
                     rd_hit(ex_rd_wren_i, ex_rd_ad_i, id_rs2_addr_i));

  assign wait_cnt_inc = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
  assign wait_expired = (wait_cnt_inc >= WCNT_W'(MEM_TIMEOUT));

  // Stage control decode. MEM_WAIT decodes like RUN: busy holds, release resolves normally.
  always_comb begin
    pc_en_o    = 1'b1;
    if_id_sel  = SEL_LOAD;
    id_ex_sel  = SEL_LOAD;
    ex_mem_sel = SEL_LOAD;
    mem_wb_sel = SEL_LOAD;
    if (!rst_ni || (state_q == TIMEOUT)) begin
      pc_en_o    = 1'b0;
      if_id_sel  = SEL_FLUSH;
      id_ex_sel  = SEL_FLUSH;
      ex_mem_sel = SEL_FLUSH;
      mem_wb_sel = SEL_FLUSH;
    end else if (mem_busy_i) begin
      pc_en_o    = 1'b0;
      if_id_sel  = SEL_HOLD;
      id_ex_sel  = SEL_HOLD;
      ex_mem_sel = SEL_HOLD;
      mem_wb_sel = SEL_HOLD;
    end else if (ex_br_taken_i) begin
      if_id_sel = SEL_FLUSH;
      id_ex_sel = SEL_FLUSH;
    end else if (load_use) begin
      pc_en_o   = 1'b0;
      if_id_sel = SEL_HOLD;
      id_ex_sel = SEL_FLUSH;
    end
  end

  assign if_id_sel_o   = if_id_sel;
  assign id_ex_sel_o   = id_ex_sel;
  assign ex_mem_sel_o  = ex_mem_sel;
  assign mem_wb_sel_o  = mem_wb_sel;
  assign mem_timeout_o = (state_q == TIMEOUT);

  // Sequencing between normal flow, memory wait and the terminal timeout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (mem_busy_i) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= WCNT_W'(1);
          end
        end
        MEM_WAIT: begin
          if (!mem_busy_i) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_inc;
            if (wait_expired) state_q <= TIMEOUT;
          end
        end
        TIMEOUT: ;
        default: begin
          state_q    <= RUN;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  fwd_unit u_fwd_a (
    .ex_rs_addr  (ex_rs1_addr_i),
    .mem_rd_ad   (mem_rd_ad_i),
    .mem_rd_wren (mem_rd_wren_i),
    .mem_wb_sel  (mem_wb_sel_i),
    .wb_rd_ad    (wb_rd_ad_i),
    .wb_rd_wren  (wb_rd_wren_i),
    .fwd         (fwd_a)
  );

  fwd_unit u_fwd_b (
    .ex_rs_addr  (ex_rs2_addr_i),
    .mem_rd_ad   (mem_rd_ad_i),
    .mem_rd_wren (mem_rd_wren_i),
    .mem_wb_sel  (mem_wb_sel_i),
    .wb_rd_ad    (wb_rd_ad_i),
    .wb_rd_wren  (wb_rd_wren_i),
    .fwd         (fwd_b)
  );

  assign fwd_a_o = rst_ni ? fwd_a : FWD_RF;
  assign fwd_b_o = rst_ni ? fwd_b : FWD_RF;

`ifdef HAZARD_PERF_EN
  logic br_flush;

  assign br_flush = rst_ni && (state_q != TIMEOUT) && !mem_busy_i && ex_br_taken_i;

  // Saturating counters of stalled cycles and branch flushes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (!pc_en_o && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (br_flush && (flush_cnt_o != '1)) flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end
`else
  // CNT_W only sizes the optional counters; a zero width is never meaningful.
  if (CNT_W == 0) begin : g_cnt_w_zero
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: the driver pushes the hand-computed response for each
// cycle, a monitor on the falling edge pops and compares.
module tb_hazard_ctrl;

  localparam int unsigned TB_TIMEOUT = 4;
  localparam int unsigned TB_CNT_W   = 16;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [4:0] id_rs1_addr_i, id_rs2_addr_i, ex_rs1_addr_i, ex_rs2_addr_i;
  logic [4:0] ex_rd_ad_i, mem_rd_ad_i, wb_rd_ad_i;
  logic       ex_rd_wren_i, ex_br_taken_i, mem_rd_wren_i, wb_rd_wren_i, mem_busy_i;
  logic [1:0] ex_wb_sel_i, mem_wb_sel_i;
  logic       pc_en_o, mem_timeout_o;
  logic [1:0] if_id_sel_o, id_ex_sel_o, ex_mem_sel_o, mem_wb_sel_o, fwd_a_o, fwd_b_o;
`ifdef HAZARD_PERF_EN
  logic [TB_CNT_W-1:0] stall_cnt_o, flush_cnt_o;
`endif

  hazard_ctrl #(.MEM_TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .id_rs1_addr_i (id_rs1_addr_i),
    .id_rs2_addr_i (id_rs2_addr_i),
    .ex_rs1_addr_i (ex_rs1_addr_i),
    .ex_rs2_addr_i (ex_rs2_addr_i),
    .ex_rd_ad_i    (ex_rd_ad_i),
    .ex_rd_wren_i  (ex_rd_wren_i),
    .ex_wb_sel_i   (ex_wb_sel_i),
    .ex_br_taken_i (ex_br_taken_i),
    .mem_rd_ad_i   (mem_rd_ad_i),
    .mem_rd_wren_i (mem_rd_wren_i),
    .mem_wb_sel_i  (mem_wb_sel_i),
    .wb_rd_ad_i    (wb_rd_ad_i),
    .wb_rd_wren_i  (wb_rd_wren_i),
    .mem_busy_i    (mem_busy_i),
    .pc_en_o       (pc_en_o),
    .if_id_sel_o   (if_id_sel_o),
    .id_ex_sel_o   (id_ex_sel_o),
    .ex_mem_sel_o  (ex_mem_sel_o),
    .mem_wb_sel_o  (mem_wb_sel_o),
    .fwd_a_o       (fwd_a_o),
    .fwd_b_o       (fwd_b_o),
`ifdef HAZARD_PERF_EN
    .stall_cnt_o   (stall_cnt_o),
    .flush_cnt_o   (flush_cnt_o),
`endif
    .mem_timeout_o (mem_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       nm;
    logic [13:0] v;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // {pc_en, if_id, id_ex, ex_mem, mem_wb, fwd_a, fwd_b, timeout}
  function automatic logic [13:0] mk(input logic pc, input logic [1:0] a, input logic [1:0] b,
                                     input logic [1:0] c, input logic [1:0] d,
                                     input logic [1:0] fa, input logic [1:0] fb, input logic to);
    return {pc, a, b, c, d, fa, fb, to};
  endfunction

  logic [13:0] ALL_LOAD, ALL_HOLD, RST_EXP, TO_EXP, LU_EXP, BR_EXP;

  // Monitor: every falling edge with a pending expectation is one comparison.
  always @(negedge clk_i) begin
    if (sb_q.size() > 0) begin
      exp_t        e;
      logic [13:0] act;
      e   = sb_q.pop_front();
      act = {pc_en_o, if_id_sel_o, id_ex_sel_o, ex_mem_sel_o, mem_wb_sel_o,
             fwd_a_o, fwd_b_o, mem_timeout_o};
      n_checks++;
      if (act !== e.v) begin
        n_errors++;
        $display("FAIL %s: got %b expected %b", e.nm, act, e.v);
      end
    end
  end

  task automatic cyc(input string nm, input logic [13:0] v);
    exp_t e;
    e.nm = nm;
    e.v  = v;
    sb_q.push_back(e);
    @(posedge clk_i);
    #1;
  endtask

  task automatic clr_in();
    id_rs1_addr_i = '0; id_rs2_addr_i = '0; ex_rs1_addr_i = '0; ex_rs2_addr_i = '0;
    ex_rd_ad_i = '0; mem_rd_ad_i = '0; wb_rd_ad_i = '0;
    ex_rd_wren_i = 1'b0; ex_br_taken_i = 1'b0; mem_rd_wren_i = 1'b0; wb_rd_wren_i = 1'b0;
    mem_busy_i = 1'b0; ex_wb_sel_i = 2'b00; mem_wb_sel_i = 2'b00;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    ex_rd_ad_i = rd; ex_rd_wren_i = 1'b1; ex_wb_sel_i = 2'b01;
    id_rs1_addr_i = rs1; id_rs2_addr_i = rs2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    ALL_LOAD = mk(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    ALL_HOLD = mk(1'b0, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
    RST_EXP  = mk(1'b0, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0);
    TO_EXP   = mk(1'b0, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 1'b1);
    LU_EXP   = mk(1'b0, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    BR_EXP   = mk(1'b1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

    rst_ni = 1'b0;
    clr_in();
    @(posedge clk_i);
    #1;

    // Reset: flush everything and suppress forwarding even with a live match.
    mem_rd_ad_i = 5'd3; mem_rd_wren_i = 1'b1; ex_rs1_addr_i = 5'd3;
    cyc("reset_fwd_live", RST_EXP);
    clr_in();
    cyc("reset_idle", RST_EXP);

    rst_ni = 1'b1;
    cyc("idle_0", ALL_LOAD);
    cyc("idle_1", ALL_LOAD);

    // Load-use on rs1, then the bubble reaches EX.
    set_lu(5'd5, 5'd5, 5'd1);
    cyc("lu_rs1", LU_EXP);
    clr_in();
    cyc("lu_after", ALL_LOAD);
    set_lu(5'd5, 5'd1, 5'd5);
    cyc("lu_rs2", LU_EXP);
    set_lu(5'd0, 5'd0, 5'd1);
    cyc("lu_x0", ALL_LOAD);
    set_lu(5'd5, 5'd5, 5'd1);
    ex_wb_sel_i = 2'b00;
    cyc("lu_alu_src", ALL_LOAD);
    set_lu(5'd5, 5'd5, 5'd1);
    ex_rd_wren_i = 1'b0;
    cyc("lu_no_wren", ALL_LOAD);

    // Branch beats load-use.
    set_lu(5'd5, 5'd5, 5'd1);
    ex_br_taken_i = 1'b1;
    cyc("br_over_lu", BR_EXP);
    clr_in();

    // Memory wait of 3 cycles; a branch in the release cycle is resolved immediately.
    mem_busy_i = 1'b1;
    ex_br_taken_i = 1'b1;
    cyc("busy_1", ALL_HOLD);
    cyc("busy_2", ALL_HOLD);
    cyc("busy_3", ALL_HOLD);
    mem_busy_i = 1'b0;
    cyc("busy_rel_br", BR_EXP);
    clr_in();
    cyc("busy_after", ALL_LOAD);

    // Release cycle re-detects load-use from the held stages.
    mem_busy_i = 1'b1;
    cyc("busy2_1", ALL_HOLD);
    mem_busy_i = 1'b0;
    set_lu(5'd7, 5'd7, 5'd7);
    cyc("busy2_rel_lu", LU_EXP);
    clr_in();

    // Forwarding priority.
    mem_rd_ad_i = 5'd3; mem_rd_wren_i = 1'b1; wb_rd_ad_i = 5'd3; wb_rd_wren_i = 1'b1;
    ex_rs1_addr_i = 5'd3; ex_rs2_addr_i = 5'd7;
    cyc("fwd_mem_a", mk(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0));
    mem_wb_sel_i = 2'b01;
    cyc("fwd_load_to_wb", mk(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0));
    mem_wb_sel_i = 2'b00; ex_rs1_addr_i = 5'd9; ex_rs2_addr_i = 5'd3;
    cyc("fwd_mem_b", mk(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0));
    mem_rd_wren_i = 1'b0; ex_rs1_addr_i = 5'd3;
    cyc("fwd_wb_both", mk(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 1'b0));
    mem_rd_ad_i = 5'd0; mem_rd_wren_i = 1'b1; wb_rd_ad_i = 5'd0; ex_rs1_addr_i = 5'd0;
    ex_rs2_addr_i = 5'd0;
    cyc("fwd_x0", ALL_LOAD);
    clr_in();

    // Stuck memory: 4 held cycles, then terminal timeout.
    mem_busy_i = 1'b1;
    for (int i = 0; i < int'(TB_TIMEOUT); i++) cyc($sformatf("stuck_hold_%0d", i), ALL_HOLD);
    cyc("timeout_0", TO_EXP);
    mem_busy_i = 1'b0;
    cyc("timeout_sticky", TO_EXP);
    ex_br_taken_i = 1'b1;
    cyc("timeout_br", TO_EXP);
    clr_in();

    rst_ni = 1'b0;
    cyc("timeout_reset", RST_EXP);
    rst_ni = 1'b1;
    cyc("after_reset", ALL_LOAD);

    // Reset in the middle of a wait returns to RUN.
    mem_busy_i = 1'b1;
    cyc("midwait_1", ALL_HOLD);
    cyc("midwait_2", ALL_HOLD);
    rst_ni = 1'b0;
    cyc("midwait_reset", RST_EXP);
    rst_ni = 1'b1;
    mem_busy_i = 1'b0;
    cyc("midwait_after", ALL_LOAD);

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk_i);
    if (sb_q.size() > 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
